// File: rtl/moore_det_scheduler.sv
// Round-robin scheduler sharing one bit-serial Moore toggle detector between two requesters.
// Each accepted word is cleared into the detector, shifted LSB first, and the per-bit results are returned.
module moore_det_scheduler #(
  parameter int W       = 8,
  parameter int DET_LAT = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [1:0]   req_valid,
  input  logic [W-1:0] req_data0,
  input  logic [W-1:0] req_data1,
  output logic [1:0]   req_ready,
  output logic [1:0]   resp_valid,
  output logic [W-1:0] resp_data,
  output logic         busy,
  output logic         det_clr,
  output logic         det_inp,
  input  logic         det_out
);

  localparam int CW = $clog2(W + DET_LAT + 1);
  localparam int IW = $clog2(W);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_SHIFT = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t         r_state;
  state_t         w_next;
  logic           w_gnt_vld;
  logic           w_gnt_idx;
  logic           r_rr;
  logic           r_gnt;
  logic [CW-1:0]  r_cnt;
  logic [W-1:0]   r_shift;
  logic [W-1:0]   r_cap;
  logic [W-1:0]   w_cap;
  logic [1:0]     r_req_ready;
  logic [1:0]     r_resp_valid;
  logic [W-1:0]   r_resp_data;
  logic           r_busy;
  logic           r_det_clr;
  logic           r_det_inp;
  logic [DET_LAT:1] r_pv;
  logic [IW-1:0]  r_pidx [1:DET_LAT];

  // Next-state and grant selection
  always_comb begin
    w_next    = r_state;
    w_gnt_vld = 1'b0;
    w_gnt_idx = r_rr;
    case (r_state)
      S_IDLE: begin
        if (req_valid != 2'b00) begin
          w_gnt_vld = 1'b1;
          if (req_valid == 2'b11) begin
            w_gnt_idx = r_rr;
          end else begin
            w_gnt_idx = req_valid[1];
          end
          w_next = S_CLEAR;
        end else begin
          w_next = S_IDLE;
        end
      end
      S_CLEAR: w_next = S_SHIFT;
      S_SHIFT: begin
        if (r_cnt == CW'(W - 1)) begin
          w_next = S_DRAIN;
        end else begin
          w_next = S_SHIFT;
        end
      end
      S_DRAIN: begin
        if (r_cnt == CW'(DET_LAT - 1)) begin
          w_next = S_DONE;
        end else begin
          w_next = S_DRAIN;
        end
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Result bit for the index that left the detector pipeline this cycle
  always_comb begin
    w_cap = r_cap;
    if (r_pv[DET_LAT]) begin
      w_cap[r_pidx[DET_LAT]] = det_out;
    end else begin
      w_cap = r_cap;
    end
  end

  // Delayed bit-index pipeline: stage DET_LAT lines up with det_out for that bit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pv <= '0;
      for (int i = 1; i <= DET_LAT; i++) begin
        r_pidx[i] <= '0;
      end
    end else begin
      r_pv[1]   <= (r_state == S_SHIFT);
      r_pidx[1] <= r_cnt[IW-1:0];
      for (int i = 2; i <= DET_LAT; i++) begin
        r_pv[i]   <= r_pv[i-1];
        r_pidx[i] <= r_pidx[i-1];
      end
    end
  end

  // FSM state, datapath and registered outputs (all derived from the next state)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_rr         <= 1'b0;
      r_gnt        <= 1'b0;
      r_cnt        <= '0;
      r_shift      <= '0;
      r_cap        <= '0;
      r_req_ready  <= 2'b00;
      r_resp_valid <= 2'b00;
      r_resp_data  <= '0;
      r_busy       <= 1'b0;
      r_det_clr    <= 1'b0;
      r_det_inp    <= 1'b1;
    end else begin
      r_state   <= w_next;
      r_cnt     <= (w_next != r_state) ? {CW{1'b0}} : r_cnt + CW'(1);
      r_busy    <= (w_next != S_IDLE);
      r_det_clr <= (w_next == S_CLEAR);
      // Idle and drain drive 1 so the detector holds its state
      r_det_inp <= (w_next == S_SHIFT) ? r_shift[0] : 1'b1;
      r_req_ready <= w_gnt_vld ? (2'b01 << w_gnt_idx) : 2'b00;

      if (w_gnt_vld) begin
        r_gnt   <= w_gnt_idx;
        r_shift <= w_gnt_idx ? req_data1 : req_data0;
        r_cap   <= '0;
      end else if (w_next == S_SHIFT) begin
        r_shift <= r_shift >> 1;
        r_cap   <= w_cap;
      end else begin
        r_cap   <= w_cap;
      end

      if (w_next == S_DONE) begin
        r_resp_valid <= 2'b01 << r_gnt;
        r_resp_data  <= w_cap;
      end else begin
        r_resp_valid <= 2'b00;
      end

      if (r_state == S_DONE) begin
        r_rr <= ~r_gnt;
      end else begin
        r_rr <= r_rr;
      end
    end
  end

  assign req_ready  = r_req_ready;
  assign resp_valid = r_resp_valid;
  assign resp_data  = r_resp_data;
  assign busy       = r_busy;
  assign det_clr    = r_det_clr;
  assign det_inp    = r_det_inp;

endmodule

// File: tb/tb_moore_det_scheduler.sv
// Self-checking bench: behavioural detector, transaction-level scheduler model, directed and random traffic.
module tb_moore_det_scheduler;

  localparam int W    = 8;
  localparam int DL   = 2;
  localparam int LAST = W + DL + 2;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [1:0]   req_valid = 2'b00;
  logic [W-1:0] d0 = '0;
  logic [W-1:0] d1 = '0;
  logic [1:0]   req_ready;
  logic [1:0]   resp_valid;
  logic [W-1:0] resp_data;
  logic         busy;
  logic         det_clr;
  logic         det_inp;
  logic         det_out;

  int n_checks = 0;
  int n_errors = 0;
  logic chk_en = 1'b0;

  always #5 clk = ~clk;

  moore_det_scheduler #(.W(W), .DET_LAT(DL)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data0(d0), .req_data1(d1),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_data(resp_data), .busy(busy),
    .det_clr(det_clr), .det_inp(det_inp), .det_out(det_out)
  );

  // Moore toggle detector: 0 toggles, 1 holds, out registered from state
  logic d_state = 1'b1;
  logic d_out   = 1'b1;
  always @(posedge clk or posedge det_clr) begin
    if (det_clr) begin
      d_state <= 1'b1;
      d_out   <= 1'b1;
    end else begin
      d_state <= det_inp ? d_state : ~d_state;
      d_out   <= d_state;
    end
  end
  assign det_out = d_out;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] ref_resp(input logic [W-1:0] w);
    logic [W-1:0] r;
    int z;
    z = 0;
    r = '0;
    for (int k = 0; k < W; k++) begin
      if (w[k] == 1'b0) z++;
      r[k] = ((z % 2) == 0);
    end
    return r;
  endfunction

  // Transaction-level model: m_rel counts cycles since the grant decision
  logic         m_act = 1'b0;
  int           m_rel = 0;
  logic         m_win = 1'b0;
  logic         m_rr  = 1'b0;
  logic [W-1:0] m_word = '0;
  logic [W-1:0] m_resp = '0;

  always @(posedge clk or posedge rst) begin
    logic g;
    if (rst) begin
      m_act <= 1'b0; m_rel <= 0; m_win <= 1'b0; m_rr <= 1'b0; m_word <= '0; m_resp <= '0;
    end else if (m_act) begin
      if (m_rel == LAST) begin
        m_act <= 1'b0;
        m_rr  <= ~m_win;
      end else begin
        m_rel <= m_rel + 1;
        if (m_rel + 1 == LAST) m_resp <= ref_resp(m_word);
      end
    end else if (req_valid != 2'b00) begin
      g = (req_valid == 2'b11) ? m_rr : req_valid[1];
      m_act  <= 1'b1;
      m_rel  <= 1;
      m_win  <= g;
      m_word <= g ? d1 : d0;
    end
  end

  always @(negedge clk) begin
    logic [1:0] oh;
    logic       e_inp;
    if (!rst && chk_en) begin
      oh = 2'b01 << m_win;
      e_inp = (m_act && m_rel >= 2 && m_rel <= W + 1) ? m_word[m_rel-2] : 1'b1;
      check("req_ready", req_ready, (m_act && m_rel == 1) ? oh : 2'b00);
      check("det_clr", det_clr, (m_act && m_rel == 1));
      check("det_inp", det_inp, e_inp);
      check("busy", busy, m_act);
      check("resp_valid", resp_valid, (m_act && m_rel == LAST) ? oh : 2'b00);
      check("resp_data", resp_data, m_resp);
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"}, req_ready, 2'b00);
    check({tag, "_resp_valid"}, resp_valid, 2'b00);
    check({tag, "_resp_data"}, resp_data, 8'h00);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_det_clr"}, det_clr, 1'b0);
    check({tag, "_det_inp"}, det_inp, 1'b1);
  endtask

  task automatic wait_ready(input int i);
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (req_ready[i]) return;
    end
    n_checks++; n_errors++;
    $display("FAIL ready_timeout: requester %0d got no req_ready within 60 cycles", i);
  endtask

  task automatic wait_resp(output logic [1:0] idx, output logic [W-1:0] data, output int lat);
    lat = 0; idx = 2'b00; data = '0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      lat++;
      if (resp_valid != 2'b00) begin
        idx = resp_valid; data = resp_data;
        return;
      end
    end
    n_checks++; n_errors++;
    $display("FAIL resp_timeout: got no resp_valid within 60 cycles");
  endtask

  task automatic send(input int i, input logic [W-1:0] d, input logic [W-1:0] exp);
    logic [1:0] idx; logic [W-1:0] data; int lat;
    if (i == 0) d0 = d; else d1 = d;
    req_valid[i] = 1'b1;
    wait_ready(i);
    req_valid[i] = 1'b0;
    wait_resp(idx, data, lat);
    check("send_data", data, exp);
    check("send_idx", idx, 2'b01 << i);
    check("send_latency", lat, LAST - 1);
  endtask

  initial begin
    logic [1:0] idx; logic [W-1:0] data; int lat;
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    chk_en = 1'b1;

    // Directed words with hand-computed responses
    send(0, 8'h00, 8'hAA);
    send(1, 8'hFF, 8'hFF);
    send(1, 8'hFE, 8'h00);
    send(1, 8'h0F, 8'hAF);

    // Continuous contention from reset: strict alternation
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    d0 = 8'h00; d1 = 8'hFF; req_valid = 2'b11;
    for (int j = 0; j < 4; j++) begin
      wait_resp(idx, data, lat);
      check("alt_idx", idx, (j % 2) ? 2'b10 : 2'b01);
      check("alt_data", data, (j % 2) ? 8'hFF : 8'hAA);
    end
    req_valid = 2'b00;
    repeat (LAST + 2) @(negedge clk);

    // Request while busy waits until after DONE
    d0 = 8'h00; req_valid = 2'b01;
    wait_ready(0);
    req_valid = 2'b00;
    repeat (3) @(negedge clk);
    d1 = 8'h0F; req_valid[1] = 1'b1;
    wait_resp(idx, data, lat);
    check("busy_first_idx", idx, 2'b01);
    check("busy_first_data", data, 8'hAA);
    wait_ready(1);
    req_valid = 2'b00;
    wait_resp(idx, data, lat);
    check("busy_second_idx", idx, 2'b10);
    check("busy_second_data", data, 8'hAF);

    // Reset in the middle of SHIFT, leaving the detector toggled
    d0 = 8'h00; req_valid = 2'b01;
    wait_ready(0);
    req_valid = 2'b00;
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    #1 check_reset_outputs("midrst");
    @(negedge clk) rst = 1'b0;
    repeat (LAST + 2) @(negedge clk);
    send(0, 8'h00, 8'hAA);

    // Data changes after accept are ignored
    d0 = 8'h00; req_valid = 2'b01;
    wait_ready(0);
    d0 = 8'hFF; req_valid = 2'b00;
    wait_resp(idx, data, lat);
    check("late_data", data, 8'hAA);

    // Random traffic against the model
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (req_valid[i]) begin
          if (req_ready[i]) begin
            req_valid[i] = 1'b0;
            if (i == 0) d0 = W'($urandom); else d1 = W'($urandom);
          end else if ($urandom_range(15) == 0) begin
            req_valid[i] = 1'b0;
          end
        end else if ($urandom_range(3) == 0) begin
          if (i == 0) d0 = W'($urandom); else d1 = W'($urandom);
          req_valid[i] = 1'b1;
        end
      end
    end
    req_valid = 2'b00;
    repeat (LAST + 4) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
